// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core constants and the fetch-stage state encoding.
package chip8_pkg;

  localparam int unsigned       ADDR_W    = 12;
  localparam int unsigned       OPCODE_W  = 16;
  localparam logic [ADDR_W-1:0] RESET_PC  = 12'h200;
  localparam logic [ADDR_W-1:0] FONT_BASE = 12'h000;

  typedef enum logic [1:0] {
    HI_ADDR = 2'd0,
    HI_DATA = 2'd1,
    LO_DATA = 2'd2,
    VALID   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: reads two big-endian bytes from chip8_mem, presents
// the opcode over valid/ready and applies jump/skip redirects at handshake.
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int unsigned       ADDR_W   = chip8_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(chip8_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_data,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   op_pc,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_addr,
  input  logic                pc_skip
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  op_valid_q, op_valid_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [ADDR_W-1:0]     op_pc_q, op_pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HI_ADDR;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      op_valid_q <= 1'b0;
      opcode_q   <= '0;
      op_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      op_valid_q <= op_valid_d;
      opcode_q   <= opcode_d;
      op_pc_q    <= op_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_valid_d = op_valid_q;
    opcode_d   = opcode_q;
    op_pc_d    = op_pc_q;

    unique case (state_q)
      HI_ADDR: begin
        if (run) state_d = HI_DATA;
      end
      HI_DATA: begin
        opcode_d[15:8] = mem_data;
        state_d        = LO_DATA;
      end
      LO_DATA: begin
        opcode_d[7:0] = mem_data;
        op_pc_d       = pc_q;
        op_valid_d    = 1'b1;
        state_d       = VALID;
      end
      VALID: begin
        if (op_valid_q && op_ready) begin
          op_valid_d = 1'b0;
          state_d    = HI_ADDR;
          if (pc_load)      pc_d = pc_load_addr;
          else if (pc_skip) pc_d = pc_q + ADDR_W'(4);
          else              pc_d = pc_q + ADDR_W'(2);
        end
      end
      default: state_d = HI_ADDR;
    endcase

    // Address is registered from next state so memory sees it with no input-to-output path
    unique case (state_d)
      HI_DATA, LO_DATA: mem_addr_d = pc_d + ADDR_W'(1);
      default:          mem_addr_d = pc_d;
    endcase
  end

  assign mem_addr = mem_addr_q;
  assign op_valid = op_valid_q;
  assign opcode   = opcode_q;
  assign op_pc    = op_pc_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed self-checking bench for chip8_fetch with a synchronous-read memory model.
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic [11:0] op_pc;
  logic        pc_load;
  logic [11:0] pc_load_addr;
  logic        pc_skip;

  logic [7:0]  mem [4096];
  int          n_cmp = 0;
  int          n_err = 0;

  chip8_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .opcode       (opcode),
    .op_pc        (op_pc),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .pc_skip      (pc_skip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  function automatic logic [15:0] exp_op(input logic [11:0] a);
    logic [11:0] b;
    b = a + 12'd1;
    return {mem[a], mem[b]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !op_valid; i++) tick();
    check({tag, "_valid"}, 32'(op_valid), 32'd1);
  endtask

  // One handshake with the given redirect, then the next presented opcode is checked
  task automatic hs(input string tag, input logic ld, input logic [11:0] addr,
                    input logic sk, input logic [11:0] exp_pc);
    op_ready = 1'b1; pc_load = ld; pc_load_addr = addr; pc_skip = sk;
    tick();
    op_ready = 1'b0; pc_load = 1'b0; pc_skip = 1'b0; pc_load_addr = 12'h5A5;
    check({tag, "_drop"}, 32'(op_valid), 32'd0);
    wait_valid(tag);
    check({tag, "_pc"}, 32'(op_pc), 32'(exp_pc));
    check({tag, "_op"}, 32'(opcode), 32'(exp_op(exp_pc)));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hF0;

    rst_n = 1'b0; run = 1'b1; op_ready = 1'b1;
    pc_load = 1'b0; pc_skip = 1'b0; pc_load_addr = 12'h000;
    #13;
    check("rst_valid", 32'(op_valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'h0000);
    check("rst_op_pc", 32'(op_pc), 32'h200);
    check("rst_addr", 32'(mem_addr), 32'h200);
    #4 rst_n = 1'b1;
    #4;

    // First fetch: valid on the 3rd edge
    tick(); check("lat1", 32'(op_valid), 32'd0);
    tick(); check("lat2", 32'(op_valid), 32'd0);
    tick(); check("lat3", 32'(op_valid), 32'd1);
    check("first_op", 32'(opcode), 32'h1234);
    check("first_pc", 32'(op_pc), 32'h200);

    // op_ready held high: next opcode exactly 4 cycles later
    for (int i = 0; i < 3; i++) tick();
    check("thru_gap", 32'(op_valid), 32'd0);
    tick();
    check("thru_valid", 32'(op_valid), 32'd1);
    check("thru_pc", 32'(op_pc), 32'h202);
    op_ready = 1'b0;

    // Backpressure plus ignored redirect requests without handshake
    for (int i = 0; i < 10; i++) begin
      pc_load = (i == 3); pc_skip = (i == 5); pc_load_addr = 12'h500;
      tick();
      check("bp_valid", 32'(op_valid), 32'd1);
      check("bp_op", 32'(opcode), 32'(exp_op(12'h202)));
      check("bp_pc", 32'(op_pc), 32'h202);
      check("bp_addr", 32'(mem_addr), 32'h202);
    end
    pc_load = 1'b0; pc_skip = 1'b0;
    hs("plain", 1'b0, 12'h000, 1'b0, 12'h204);

    hs("jump", 1'b1, 12'h300, 1'b0, 12'h300);
    hs("skip", 1'b0, 12'h000, 1'b1, 12'h304);
    hs("both", 1'b1, 12'h400, 1'b1, 12'h400);
    hs("odd", 1'b1, 12'h123, 1'b0, 12'h123);

    // Address wrap
    hs("wrap_fff", 1'b1, 12'hFFF, 1'b0, 12'hFFF);
    check("wrap_opcode", 32'(opcode), 32'hABF0);
    check("wrap_addr", 32'(mem_addr), 32'hFFF);
    hs("to_ffe", 1'b1, 12'hFFE, 1'b0, 12'hFFE);
    hs("wrap_000", 1'b0, 12'h000, 1'b0, 12'h000);

    // Reset asserted during LO_DATA
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    tick(); check("mid_hi_addr", 32'(mem_addr), 32'h003);
    tick(); check("mid_lo_addr", 32'(mem_addr), 32'h003);
    #2 rst_n = 1'b0; run = 1'b0;
    #1;
    check("mid_rst_valid", 32'(op_valid), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'h200);
    check("mid_rst_op_pc", 32'(op_pc), 32'h200);
    check("mid_rst_opcode", 32'(opcode), 32'h0000);
    #3 rst_n = 1'b1;

    // run = 0 holds in HI_ADDR
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", 32'(op_valid), 32'd0);
      check("idle_addr", 32'(mem_addr), 32'h200);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    check("gate_hi_data", 32'(mem_addr), 32'h201);
    wait_valid("gate_fetch");
    check("gate_pc", 32'(op_pc), 32'h200);
    check("gate_op", 32'(opcode), 32'h1234);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_idle_valid", 32'(op_valid), 32'd0);
      check("gate_idle_addr", 32'(mem_addr), 32'h202);
    end
    run = 1'b1;
    wait_valid("gate_resume");
    check("gate_resume_pc", 32'(op_pc), 32'h202);
    check("gate_resume_op", 32'(opcode), 32'(exp_op(12'h202)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
